// File: rtl/anubis_decrypt_core_if.sv
// anubis_decrypt_core_if: request, key-store and result signals of the Anubis decryption core.
interface anubis_decrypt_core_if;
   logic         start;
   logic [127:0] cin;
   logic [4:0]   rk_addr;
   logic [127:0] rk_data;
   logic         busy;
   logic         done;
   logic [127:0] pout;
   modport master (output start, cin, rk_data, input rk_addr, busy, done, pout);
   modport slave (input start, cin, rk_data, output rk_addr, busy, done, pout);
endinterface

// File: rtl/anubis_decrypt_core.sv
// anubis_decrypt_core: iterative Anubis decryption, one round per clock, deriving the
// decryption keys from the encryption key store on the fly.
module anubis_decrypt_core #(
   parameter int ROUNDS = 12
) (
   input logic clk,
   input logic rst,
   anubis_decrypt_core_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WHITEN, ROUND, FINAL} state_t;
   localparam logic [4:0] R5 = 5'(ROUNDS);
   localparam logic [63:0] P_BOX = 64'h3FE054BCDA967821;
   localparam logic [63:0] Q_BOX = 64'h9E56A23CF04D7B18;
   state_t state_q, state_d;
   logic [127:0] st_q, st_d, pout_q, pout_d, tg, rnd_full, rnd_last;
   logic [4:0] rc_q, rc_d, addr_q, addr_d;
   logic done_q, done_d;
   function automatic logic [3:0] p_box(input logic [3:0] x);
      return P_BOX[{~x, 2'b11} -: 4];
   endfunction
   function automatic logic [3:0] q_box(input logic [3:0] x);
      return Q_BOX[{~x, 2'b11} -: 4];
   endfunction
   // Involutional S-box: P|Q, bit cross, Q|P, bit cross, P|Q.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] a, b;
      a = {p_box(x[7:4]), q_box(x[3:0])};
      b = {a[7:6], a[3:2], a[5:4], a[1:0]};
      a = {q_box(b[7:4]), p_box(b[3:0])};
      b = {a[7:6], a[3:2], a[5:4], a[1:0]};
      return {p_box(b[7:4]), q_box(b[3:0])};
   endfunction
   function automatic logic [127:0] gamma(input logic [127:0] a);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox(a[8*k +: 8]);
      return r;
   endfunction
   function automatic logic [127:0] tau(input logic [127:0] a);
      logic [127:0] r;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) r[127-8*(4*i+j) -: 8] = a[127-8*(4*j+i) -: 8];
      return r;
   endfunction
   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
   endfunction
   function automatic logic [7:0] mulh(input logic [7:0] x, input logic [1:0] h);
      return h == 2'd0 ? x : h == 2'd1 ? xt(x) : h == 2'd2 ? xt(xt(x)) : xt(xt(x)) ^ xt(x);
   endfunction
   // Row-vector times had(01,02,04,06) over GF(2^8) mod x^8+x^4+x^3+x^2+1.
   function automatic logic [127:0] theta(input logic [127:0] a);
      logic [127:0] r;
      logic [7:0] acc;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            acc = '0;
            for (int k = 0; k < 4; k++) acc ^= mulh(a[127-8*(4*i+k) -: 8], 2'(k ^ j));
            r[127-8*(4*i+j) -: 8] = acc;
         end
      return r;
   endfunction
   assign tg = tau(gamma(st_q));
   assign rnd_full = theta(tg) ^ theta(bus.rk_data);
   assign rnd_last = tg ^ bus.rk_data;
   assign bus.rk_addr = addr_q;
   assign bus.busy = state_q != IDLE;
   assign bus.done = done_q;
   assign bus.pout = pout_q;
   always_comb begin
      state_d = state_q;
      st_d = st_q;
      rc_d = rc_q;
      addr_d = addr_q;
      pout_d = pout_q;
      done_d = 1'b0;
      unique case (state_q)
         IDLE: if (bus.start) begin
            st_d = bus.cin;
            addr_d = R5;
            state_d = WHITEN;
         end
         WHITEN: begin
            st_d = st_q ^ bus.rk_data;
            addr_d = R5 - 5'd1;
            rc_d = 5'd1;
            state_d = ROUND;
         end
         ROUND: begin
            st_d = rnd_full;
            addr_d = addr_q - 5'd1;
            rc_d = rc_q + 5'd1;
            state_d = rc_q == R5 - 5'd1 ? FINAL : ROUND;
         end
         FINAL: begin
            st_d = rnd_last;
            pout_d = rnd_last;
            done_d = 1'b1;
            addr_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         st_q <= '0;
         rc_q <= '0;
         addr_q <= '0;
         pout_q <= '0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         st_q <= st_d;
         rc_q <= rc_d;
         addr_q <= addr_d;
         pout_q <= pout_d;
         done_q <= done_d;
      end
endmodule

// File: tb/tb_anubis_decrypt_core.sv
// tb_anubis_decrypt_core: directed round-trip, timing, reset and hold checks against an
// independent Anubis encryption model driving a combinational-read key store.
module tb_anubis_decrypt_core;
   logic clk = 1'b0, rst = 1'b0, start = 1'b0, start18 = 1'b0, noise_en = 1'b0;
   logic [127:0] cin = '0, noise = '0, pt, pt2, ct;
   logic [127:0] rk [0:31];
   int checks = 0, errors = 0, n_done, first, second;
   logic saw;
   localparam logic [3:0] MP [16] = '{4'h3, 4'hF, 4'hE, 4'h0, 4'h5, 4'h4, 4'hB, 4'hC,
                                      4'hD, 4'hA, 4'h9, 4'h6, 4'h7, 4'h8, 4'h2, 4'h1};
   localparam logic [3:0] MQ [16] = '{4'h9, 4'hE, 4'h5, 4'h6, 4'hA, 4'h2, 4'h3, 4'hC,
                                      4'hF, 4'h0, 4'h4, 4'hD, 4'h7, 4'hB, 4'h1, 4'h8};
   localparam logic [7:0] MH [4] = '{8'h01, 8'h02, 8'h04, 8'h06};
   anubis_decrypt_core_if b12 ();
   anubis_decrypt_core_if b18 ();
   assign b12.start = start;
   assign b12.cin = cin;
   assign b12.rk_data = noise_en ? noise : rk[b12.rk_addr];
   assign b18.start = start18;
   assign b18.cin = cin;
   assign b18.rk_data = rk[b18.rk_addr];
   anubis_decrypt_core #(.ROUNDS(12)) dut12 (.clk(clk), .rst(rst), .bus(b12));
   anubis_decrypt_core #(.ROUNDS(18)) dut18 (.clk(clk), .rst(rst), .bus(b18));
   always #5 clk = ~clk;
   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r, x;
      r = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
      end
      return r;
   endfunction
   function automatic logic [7:0] msbox(input logic [7:0] x);
      logic [3:0] u, l, nu, nl;
      u = MP[x[7:4]];
      l = MQ[x[3:0]];
      nu = {u[3:2], l[3:2]};
      nl = {u[1:0], l[1:0]};
      u = MQ[nu];
      l = MP[nl];
      nu = {u[3:2], l[3:2]};
      nl = {u[1:0], l[1:0]};
      return {MP[nu], MQ[nl]};
   endfunction
   function automatic logic [127:0] m_round(input logic [127:0] a, input bit with_theta);
      logic [7:0] m [4][4];
      logic [7:0] acc;
      logic [127:0] r;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) m[j][i] = msbox(a[127-8*(4*i+j) -: 8]);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            acc = m[i][j];
            if (with_theta) begin
               acc = '0;
               for (int k = 0; k < 4; k++) acc ^= gmul(m[i][k], MH[k ^ j]);
            end
            r[127-8*(4*i+j) -: 8] = acc;
         end
      return r;
   endfunction
   function automatic logic [127:0] enc(input logic [127:0] p, input int nr);
      logic [127:0] s;
      s = p ^ rk[0];
      for (int r = 1; r < nr; r++) s = m_round(s, 1'b1) ^ rk[r];
      return m_round(s, 1'b0) ^ rk[nr];
   endfunction
   task automatic check(input logic [127:0] obs, input logic [127:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   // Called at a negedge with dut12 idle; runs one block and checks timing and result.
   task automatic dec12(input logic [127:0] p, input string tag);
      start = 1'b1;
      cin = enc(p, 12);
      @(negedge clk);
      start = 1'b0;
      cin = rand128();
      check(b12.busy, 1, {tag, " busy_e0"});
      check(b12.rk_addr, 12, {tag, " addr_e0"});
      for (int e = 1; e <= 13; e++) begin
         @(negedge clk);
         check(b12.rk_addr, e >= 12 ? 0 : 12 - e, $sformatf("%s addr_e%0d", tag, e));
         check(b12.done, e == 13, $sformatf("%s done_e%0d", tag, e));
         check(b12.busy, e < 13, $sformatf("%s busy_e%0d", tag, e));
      end
      check(b12.pout, p, {tag, " pout"});
      @(negedge clk);
      check(b12.done, 0, {tag, " done_fall"});
   endtask
   initial begin
      for (int i = 0; i < 32; i++) rk[i] = '0;
      #1 rst = 1'b1;
      #1;
      check(b12.busy, 0, "rst busy");
      check(b12.done, 0, "rst done");
      check(b12.pout, 0, "rst pout");
      check(b12.rk_addr, 0, "rst addr");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      dec12('0, "zero");
      for (int i = 0; i < 200; i++) begin
         for (int r = 0; r <= 12; r++) rk[r] = rand128();
         dec12(rand128(), $sformatf("rnd%0d", i));
      end
      for (int r = 0; r <= 18; r++) rk[r] = rand128();
      pt = rand128();
      cin = enc(pt, 18);
      start18 = 1'b1;
      @(negedge clk);
      start18 = 1'b0;
      cin = rand128();
      check(b18.rk_addr, 18, "r18 addr_e0");
      for (int e = 1; e <= 19; e++) begin
         @(negedge clk);
         check(b18.rk_addr, e >= 18 ? 0 : 18 - e, $sformatf("r18 addr_e%0d", e));
         check(b18.done, e == 19, $sformatf("r18 done_e%0d", e));
      end
      check(b18.pout, pt, "r18 pout");
      pt = rand128();
      cin = enc(pt, 12);
      start = 1'b1;
      n_done = 0;
      first = -1;
      second = -1;
      for (int n = 0; n < 32; n++) begin
         @(negedge clk);
         if (n == 19) start = 1'b0;
         if (b12.done === 1'b1) begin
            n_done++;
            if (first < 0) first = n;
            else second = n;
         end
      end
      check(n_done, 2, "hold_start done_count");
      check(first, 13, "hold_start first_done");
      check(second, 27, "hold_start second_done");
      check(b12.pout, pt, "hold_start pout");
      pt2 = rand128();
      start = 1'b1;
      cin = enc(pt2, 12);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      check(b12.busy, 0, "abort busy");
      check(b12.done, 0, "abort done");
      check(b12.pout, 0, "abort pout");
      check(b12.rk_addr, 0, "abort addr");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      saw = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (b12.done !== 1'b0) saw = 1'b1;
      end
      check(saw, 0, "abort no_done");
      dec12(pt2, "post_rst");
      noise_en = 1'b1;
      for (int n = 0; n < 50; n++) begin
         cin = rand128();
         noise = rand128();
         @(negedge clk);
         check(b12.pout, pt2, $sformatf("idle pout_%0d", n));
         check(b12.busy, 0, $sformatf("idle busy_%0d", n));
         check(b12.rk_addr, 0, $sformatf("idle addr_%0d", n));
      end
      noise_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
